// File: rtl/mem_port_arbiter_if.sv
// Bus bundle shared by the core-side masters and the memory-side slave.
// The requester drives the request fields; the responder drives stall and the response fields.
interface mem_port_arbiter_if;
  logic        en;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        stall;
  logic [31:0] rdata;
  logic        valid;
  logic        err;

  modport master (
    output en, we, addr, wdata, mask,
    input  stall, rdata, valid, err
  );

  modport slave (
    input  en, we, addr, wdata, mask,
    output stall, rdata, valid, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Merges the instruction-fetch (M0) and data (M1) master ports onto one memory slave port.
// An owner FIFO records which master issued each accepted request so in-order responses route back.
module mem_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   m0_bus,
  mem_port_arbiter_if.slave   m1_bus,
  mem_port_arbiter_if.master  s_bus,
  output logic                proto_err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          proto_err_q;
  logic          owner_q [DEPTH];

  logic full, empty, contended, gnt1, accept, pop, head;

  assign full      = (count_q == COUNT_FULL);
  assign empty     = (count_q == '0);
  assign contended = m0_bus.en & m1_bus.en;
  assign gnt1      = m1_bus.en & ~(contended & (starve_q == STARVE_MAX));

  // Request path is purely combinational from the granted master.
  assign s_bus.en    = (m0_bus.en | m1_bus.en) & ~full & ~rst;
  assign s_bus.we    = gnt1 ? m1_bus.we    : m0_bus.we;
  assign s_bus.addr  = gnt1 ? m1_bus.addr  : m0_bus.addr;
  assign s_bus.wdata = gnt1 ? m1_bus.wdata : m0_bus.wdata;
  assign s_bus.mask  = gnt1 ? m1_bus.mask  : m0_bus.mask;

  assign accept = s_bus.en & ~s_bus.stall;
  assign m0_bus.stall = m0_bus.en & ~(accept & ~gnt1);
  assign m1_bus.stall = m1_bus.en & ~(accept & gnt1);

  assign head = owner_q[rd_ptr_q];
  assign pop  = s_bus.valid & ~empty & ~rst;

  assign m0_bus.valid = pop & ~head;
  assign m1_bus.valid = pop & head;
  assign m0_bus.rdata = s_bus.rdata;
  assign m1_bus.rdata = s_bus.rdata;
  assign m0_bus.err   = s_bus.err;
  assign m1_bus.err   = s_bus.err;

  assign proto_err_o = proto_err_q;

  always_comb begin
    count_d  = count_q + CW'(accept) - CW'(pop);
    starve_d = starve_q;
    // Only an accepted grant counts as a win; a stalled M1 does not starve M0 further.
    if (accept && !gnt1) begin
      starve_d = '0;
    end else if (accept && contended && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (s_bus.valid && empty) proto_err_q <= 1'b1;
    end
  end

  // Owner storage needs no reset: entries are only read once written behind the pointers.
  always_ff @(posedge clk) begin
    if (accept) owner_q[wr_ptr_q] <= gnt1;
  end
endmodule
